// File: rtl/saxil_read_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite read slave among NUM_REQ requesters.
// One transaction in flight; a watchdog turns a hung slave into an SLVERR response.
module saxil_read_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                      user_saxil_clk,
    input  logic                      user_saxil_rst_n,
    input  logic [NUM_REQ-1:0]        s_arvalid,
    output logic [NUM_REQ-1:0]        s_arready,
    input  logic [NUM_REQ*ADDR_W-1:0] s_araddr,
    output logic [NUM_REQ-1:0]        s_rvalid,
    input  logic [NUM_REQ-1:0]        s_rready,
    output logic [DATA_W-1:0]         s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    output logic [ADDR_W-1:0]         m_araddr,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic [1:0]                m_rresp,
    output logic [7:0]                timeout_cnt
);

    localparam int unsigned IW   = $clog2(NUM_REQ);
    localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       grant_q, grant_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                drain_q, drain_d;
    logic [7:0]          tocnt_q, tocnt_d;

    logic [ADDR_W-1:0]   req_addr [NUM_REQ];
    logic [IW-1:0]       win_idx;
    logic [IW-1:0]       cand;
    logic                win_any;
    logic                wd_expire;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign req_addr[g] = s_araddr[g*ADDR_W +: ADDR_W];
    end

    // Search starts one past the last served requester so every requester gets a turn.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((32'(ptr_q) + i) % NUM_REQ);
            if (!win_any && s_arvalid[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign wd_expire = (TIMEOUT != 0) && (wd_q == WD_LAST);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        wd_d      = wd_q;
        drain_d   = drain_q;
        tocnt_d   = tocnt_q;
        s_arready = '0;
        s_rvalid  = '0;

        // A beat arriving after a DATA timeout belongs to the abandoned read; swallow it.
        if (drain_q && m_rvalid) drain_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_any && !drain_q) begin
                    s_arready[win_idx] = 1'b1;
                    grant_d = win_idx;
                    addr_d  = req_addr[win_idx];
                    wd_d    = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                wd_d = wd_q + WD_W'(1);
                if (m_arready) begin
                    state_d = DATA;
                end else if (wd_expire) begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                    if (tocnt_q != 8'hFF) tocnt_d = tocnt_q + 8'd1;
                    state_d = RESP;
                end
            end
            DATA: begin
                wd_d = wd_q + WD_W'(1);
                if (m_rvalid) begin
                    rdata_d = m_rdata;
                    rresp_d = m_rresp;
                    state_d = RESP;
                end else if (wd_expire) begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                    drain_d = 1'b1;
                    if (tocnt_q != 8'hFF) tocnt_d = tocnt_q + 8'd1;
                    state_d = RESP;
                end
            end
            RESP: begin
                s_rvalid[grant_q] = 1'b1;
                if (s_rready[grant_q]) begin
                    ptr_d   = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge user_saxil_clk or negedge user_saxil_rst_n) begin
        if (!user_saxil_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= IW'(NUM_REQ - 1);
            addr_q  <= '0;
            rdata_q <= '0;
            rresp_q <= '0;
            wd_q    <= '0;
            drain_q <= 1'b0;
            tocnt_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            wd_q    <= wd_d;
            drain_q <= drain_d;
            tocnt_q <= tocnt_d;
        end
    end

    assign m_arvalid   = (state_q == ADDR);
    assign m_rready    = (state_q == DATA) || drain_q;
    assign m_araddr    = addr_q;
    assign s_rdata     = rdata_q;
    assign s_rresp     = rresp_q;
    assign timeout_cnt = tocnt_q;

endmodule
